score_counter_bcd: RTL and testbench

- Consumes the count_up/count_down pulses from the pushbutton front end and maintains one team's score as a 2-digit BCD value.
- Edge-detects the multi-cycle input pulses, saturates at the score bounds and latches a sticky win condition.
- Its outputs feed the display driver.
- Sits between pushbutton_processor and the 7-segment multiplexer, in the clk_1khz domain.

---
 rtl/scoreboard_pkg.sv | 40 ++++
 rtl/bcd_digit_updown.sv | 32 +++
 rtl/score_counter_bcd.sv | 137 +++++++++++++
 tb/tb_score_counter_bcd.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared FSM encoding, BCD width and 7-segment patterns for the score counter
package scoreboard_pkg;

  typedef enum logic {
    PLAY = 1'b0,
    WON  = 1'b1
  } state_t;

  localparam int BCD_W = 4;

  // Active-high segment patterns, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg_encode(input logic [BCD_W-1:0] digit);
    case (digit)
      4'd0:    seg_encode = SEG_0;
      4'd1:    seg_encode = SEG_1;
      4'd2:    seg_encode = SEG_2;
      4'd3:    seg_encode = SEG_3;
      4'd4:    seg_encode = SEG_4;
      4'd5:    seg_encode = SEG_5;
      4'd6:    seg_encode = SEG_6;
      4'd7:    seg_encode = SEG_7;
      4'd8:    seg_encode = SEG_8;
      4'd9:    seg_encode = SEG_9;
      default: seg_encode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit_updown.sv
// rtl/bcd_digit_updown.sv - one BCD digit register with increment/decrement and carry/borrow out
module bcd_digit_updown
  import scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic             dec,
  output logic [BCD_W-1:0] digit,
  output logic             carry,
  output logic             borrow
);

  localparam logic [BCD_W-1:0] DIGIT_MAX = BCD_W'(9);

  // Carry/borrow are combinational so the next digit up moves on the same edge
  assign carry  = inc & (digit == DIGIT_MAX);
  assign borrow = dec & (digit == '0);

  // Digit register: wraps 9->0 on inc and 0->9 on dec, inc wins if both asserted
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      digit <= '0;
    end else if (inc) begin
      digit <= carry ? '0 : digit + BCD_W'(1);
    end else if (dec) begin
      digit <= borrow ? DIGIT_MAX : digit - BCD_W'(1);
    end
  end

endmodule

// File: rtl/score_counter_bcd.sv
// rtl/score_counter_bcd.sv - 2-digit BCD team score with edge detect, saturation and sticky win; SCORE_SEVEN_SEG_EN adds segment outputs
module score_counter_bcd
  import scoreboard_pkg::*;
#(
  parameter int MAX_SCORE = 99,
  parameter int WIN_SCORE = 21
) (
  input  logic             clk_1khz,
  input  logic             rst_i,
  input  logic             count_up_i,
  input  logic             count_down_i,
  input  logic             clear_i,
  output logic [BCD_W-1:0] tens_o,
  output logic [BCD_W-1:0] ones_o,
  output logic             win_o,
  output logic             changed_o
`ifdef SCORE_SEVEN_SEG_EN
  ,
  output logic [6:0]       seg_tens_o,
  output logic [6:0]       seg_ones_o
`endif
);

  state_t     state;
  logic       up_q;
  logic       down_q;
  logic       up_evt;
  logic       down_evt;
  logic [7:0] score_bin;
  logic       at_max;
  logic       at_zero;
  logic       hits_win;
  logic       playing;
  logic       inc_ones;
  logic       dec_ones;
  logic       ones_carry;
  logic       ones_borrow;
  logic       tens_carry;
  logic       tens_borrow;
  logic       unused_tens;

  assign up_evt   = count_up_i & ~up_q;
  assign down_evt = count_down_i & ~down_q;

  assign score_bin = 8'(tens_o) * 8'd10 + 8'(ones_o);
  assign at_max    = (score_bin == 8'(MAX_SCORE));
  assign at_zero   = (score_bin == 8'd0);
  // The increment that lands on WIN_SCORE starts from WIN_SCORE-1
  assign hits_win  = (WIN_SCORE != 0) && (score_bin == 8'(WIN_SCORE - 1));

  // Clear and WON both block counting; simultaneous events cancel
  assign playing  = (state == PLAY) & ~clear_i;
  assign inc_ones = playing & up_evt & ~down_evt & ~at_max;
  assign dec_ones = playing & down_evt & ~up_evt & ~at_zero;

  // Tens never carries or borrows out because the score saturates first
  assign unused_tens = tens_carry | tens_borrow;

  bcd_digit_updown u_ones (
    .clk    (clk_1khz),
    .rst    (rst_i),
    .clear  (clear_i),
    .inc    (inc_ones),
    .dec    (dec_ones),
    .digit  (ones_o),
    .carry  (ones_carry),
    .borrow (ones_borrow)
  );

  bcd_digit_updown u_tens (
    .clk    (clk_1khz),
    .rst    (rst_i),
    .clear  (clear_i),
    .inc    (ones_carry),
    .dec    (ones_borrow),
    .digit  (tens_o),
    .carry  (tens_carry),
    .borrow (tens_borrow)
  );

  // Edge registers track the inputs even during clear so no stale event fires later
  always_ff @(posedge clk_1khz) begin
    if (rst_i) begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
    end else begin
      up_q   <= count_up_i;
      down_q <= count_down_i;
    end
  end

  // Play/won FSM with registered win flag and change pulse
  always_ff @(posedge clk_1khz) begin
    if (rst_i) begin
      state     <= PLAY;
      win_o     <= 1'b0;
      changed_o <= 1'b0;
    end else begin
      changed_o <= inc_ones | dec_ones | (clear_i & ~at_zero);
      if (clear_i) begin
        state <= PLAY;
        win_o <= 1'b0;
      end else begin
        case (state)
          PLAY: begin
            if (inc_ones && hits_win) begin
              state <= WON;
              win_o <= 1'b1;
            end
          end
          WON: begin
            state <= WON;
            win_o <= 1'b1;
          end
          default: begin
            state <= PLAY;
            win_o <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SCORE_SEVEN_SEG_EN
  // Segment patterns registered from the digits, tens blanked when zero
  always_ff @(posedge clk_1khz) begin
    if (rst_i) begin
      seg_tens_o <= SEG_BLANK;
      seg_ones_o <= SEG_0;
    end else begin
      seg_tens_o <= (tens_o == '0) ? SEG_BLANK : seg_encode(tens_o);
      seg_ones_o <= seg_encode(ones_o);
    end
  end
`endif

endmodule

// File: tb/tb_score_counter_bcd.sv
// tb/tb_score_counter_bcd.sv - table-driven and randomized checks of score_counter_bcd against a behavioural model
module tb_score_counter_bcd;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic up = 1'b0;
  logic down = 1'b0;
  logic clr = 1'b0;

  logic [3:0] tens0, ones0, tens1, ones1;
  logic       win0, chg0, win1, chg1;
`ifdef SCORE_SEVEN_SEG_EN
  logic [6:0] segt0, sego0, segt1, sego1;
`endif

  always #5 clk = ~clk;

  // dut: default parameters; dut_nw: win detection disabled so 99 is reachable
  score_counter_bcd #(.MAX_SCORE(99), .WIN_SCORE(21)) dut (
    .clk_1khz     (clk),
    .rst_i        (rst),
    .count_up_i   (up),
    .count_down_i (down),
    .clear_i      (clr),
    .tens_o       (tens0),
    .ones_o       (ones0),
    .win_o        (win0),
    .changed_o    (chg0)
`ifdef SCORE_SEVEN_SEG_EN
    ,
    .seg_tens_o   (segt0),
    .seg_ones_o   (sego0)
`endif
  );

  score_counter_bcd #(.MAX_SCORE(99), .WIN_SCORE(0)) dut_nw (
    .clk_1khz     (clk),
    .rst_i        (rst),
    .count_up_i   (up),
    .count_down_i (down),
    .clear_i      (clr),
    .tens_o       (tens1),
    .ones_o       (ones1),
    .win_o        (win1),
    .changed_o    (chg1)
`ifdef SCORE_SEVEN_SEG_EN
    ,
    .seg_tens_o   (segt1),
    .seg_ones_o   (sego1)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: score as a plain integer per instance
  int m_max [2] = '{99, 99};
  int m_winv[2] = '{21, 0};
  int m_score[2];
  int m_win[2];
  int m_chg[2];
  int m_segt[2];
  int m_sego[2];
  bit m_pu, m_pd;

  typedef struct {
    bit r, u, d, c;
    int tens, ones, win, chg;
  } vec_t;
  vec_t vec_q[$];

  function automatic int seg_ref(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; 9: return 7'h6F;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit u, input bit d, input bit c);
    bit ue, de;
    ue = u && !m_pu;
    de = d && !m_pd;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_score[k] = 0; m_win[k] = 0; m_chg[k] = 0;
        m_segt[k] = 0; m_sego[k] = seg_ref(0);
      end else begin
        m_segt[k] = (m_score[k] / 10 == 0) ? 0 : seg_ref(m_score[k] / 10);
        m_sego[k] = seg_ref(m_score[k] % 10);
        m_chg[k] = 0;
        if (c) begin
          m_chg[k] = (m_score[k] != 0);
          m_score[k] = 0;
          m_win[k] = 0;
        end else if (!m_win[k] && (ue != de)) begin
          if (ue && m_score[k] < m_max[k]) begin
            m_score[k]++;
            m_chg[k] = 1;
            if (m_winv[k] != 0 && m_score[k] == m_winv[k]) m_win[k] = 1;
          end else if (de && m_score[k] > 0) begin
            m_score[k]--;
            m_chg[k] = 1;
          end
        end
      end
    end
    m_pu = r ? 1'b0 : u;
    m_pd = r ? 1'b0 : d;
  endtask

  task automatic compare_model();
    check("tens",     tens0, m_score[0] / 10);
    check("ones",     ones0, m_score[0] % 10);
    check("win",      win0,  m_win[0]);
    check("changed",  chg0,  m_chg[0]);
    check("nw_tens",  tens1, m_score[1] / 10);
    check("nw_ones",  ones1, m_score[1] % 10);
    check("nw_win",   win1,  m_win[1]);
    check("nw_chg",   chg1,  m_chg[1]);
`ifdef SCORE_SEVEN_SEG_EN
    check("seg_tens", segt0, m_segt[0]);
    check("seg_ones", sego0, m_sego[0]);
    check("nw_segt",  segt1, m_segt[1]);
    check("nw_sego",  sego1, m_sego[1]);
`endif
  endtask

  // Drive one cycle of inputs, advance the model, compare after the edge
  task automatic step(input bit r, input bit u, input bit d, input bit c);
    @(negedge clk);
    rst = r; up = u; down = d; clr = c;
    @(posedge clk);
    model_step(r, u, d, c);
    #1;
    compare_model();
  endtask

  task automatic add(input bit r, input bit u, input bit d, input bit c,
                     input int t, input int o, input int w, input int ch);
    vec_t v;
    v.r = r; v.u = u; v.d = d; v.c = c;
    v.tens = t; v.ones = o; v.win = w; v.chg = ch;
    vec_q.push_back(v);
  endtask

  initial begin
    m_pu = 0; m_pd = 0;
    for (int k = 0; k < 2; k++) begin
      m_score[k] = 0; m_win[k] = 0; m_chg[k] = 0; m_segt[k] = 0; m_sego[k] = 7'h3F;
    end

    // Directed vectors with hand-derived expectations for the default instance
    add(1,0,0,0, 0,0,0,0);
    add(0,1,0,0, 0,1,0,1);
    repeat (11) add(0,1,0,0, 0,1,0,0);
    add(0,0,0,0, 0,1,0,0);
    for (int i = 2; i <= 10; i++) begin
      add(0,1,0,0, i/10,i%10,0,1);
      add(0,0,0,0, i/10,i%10,0,0);
    end
    add(0,0,1,0, 0,9,0,1);
    add(0,0,0,0, 0,9,0,0);
    add(0,0,0,1, 0,0,0,1);
    add(0,0,1,0, 0,0,0,0);
    add(0,0,0,0, 0,0,0,0);
    for (int i = 1; i <= 21; i++) begin
      add(0,1,0,0, i/10,i%10,(i==21),1);
      add(0,0,0,0, i/10,i%10,(i==21),0);
    end
    add(0,1,0,0, 2,1,1,0);
    add(0,0,0,0, 2,1,1,0);
    add(0,0,1,0, 2,1,1,0);
    add(0,0,0,0, 2,1,1,0);
    add(0,0,0,1, 0,0,0,1);
    add(0,0,0,0, 0,0,0,0);
    for (int i = 1; i <= 5; i++) begin
      add(0,1,0,0, 0,i,0,1);
      add(0,0,0,0, 0,i,0,0);
    end
    add(0,1,1,0, 0,5,0,0);
    add(0,0,0,0, 0,5,0,0);
    add(0,1,0,0, 0,6,0,1);
    add(0,0,0,0, 0,6,0,0);
    add(0,1,0,1, 0,0,0,1);
    add(0,1,0,0, 0,0,0,0);
    add(0,0,0,0, 0,0,0,0);
    add(0,1,0,0, 0,1,0,1);
    add(1,1,0,0, 0,0,0,0);
    add(0,1,0,0, 0,1,0,1);
    add(0,0,0,0, 0,1,0,0);
    add(0,0,0,1, 0,0,0,1);
    add(0,0,0,1, 0,0,0,0);
    add(0,0,0,0, 0,0,0,0);

    foreach (vec_q[i]) begin
      step(vec_q[i].r, vec_q[i].u, vec_q[i].d, vec_q[i].c);
      check("vec_tens", tens0, vec_q[i].tens);
      check("vec_ones", ones0, vec_q[i].ones);
      check("vec_win",  win0,  vec_q[i].win);
      check("vec_chg",  chg0,  vec_q[i].chg);
    end

`ifdef SCORE_SEVEN_SEG_EN
    // Segment lag and leading-zero blanking
    for (int i = 0; i < 7; i++) begin
      step(0,1,0,0);
      step(0,0,0,0);
    end
    check("seg7_tens", segt0, 7'b0000000);
    check("seg7_ones", sego0, 7'b0000111);
    for (int i = 0; i < 3; i++) begin
      step(0,1,0,0);
      step(0,0,0,0);
    end
    check("seg10_tens", segt0, 7'b0000110);
    check("seg10_ones", sego0, 7'b0111111);
    step(0,0,0,1);
    step(0,0,0,0);
`endif

    // Saturation at 99 on the no-win instance
    for (int i = 0; i < 99; i++) begin
      step(0,1,0,0);
      step(0,0,0,0);
    end
    check("sat_tens", tens1, 9);
    check("sat_ones", ones1, 9);
    check("frozen_win", win0, 1);
    step(0,1,0,0);
    check("sat_chg",  chg1,  0);
    check("sat_hold", ones1, 9);
    step(0,0,0,0);
    step(0,0,1,0);
    check("down99_ones", ones1, 8);
    check("down99_chg",  chg1,  1);
    step(0,0,0,0);
    step(0,0,0,1);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 59) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
